// File: rtl/phase_generator.sv
// ----------------------------------------------------------------------------
// phase_generator
//
// Multi-phase clock-enable generator.
//
// A single one-hot token rotates around NUM_PHASES outputs. Each phase is
// held for holdCycles+1 clkIn cycles. The block can also be stepped one
// phase at a time while idle. A drained stop always parks the token on
// phase 0.
//
// Ports
//   clkIn       in   1            single clock, rising edge
//   reset       in   1            synchronous, active-high reset
//   enable      in   1            run request (level)
//   step        in   1            single-phase advance, honoured only in IDLE
//   holdCycles  in   DIV_WIDTH    phase length minus one
//   clkOut      out  NUM_PHASES   one-hot active phase (registered)
//   phaseIdx    out  clog2(N)     binary index of the clkOut bit that is set
//   cycleDone   out  1            one-cycle pulse on wrap into phase 0
//   running     out  1            high while in RUN or DRAIN
//
// State   | meaning
// --------+----------------------------------------------------------------
// IDLE    | parked; phase holds, step may advance it by one
// RUN     | phases rotate with holdCycles+1 cycles per phase
// DRAIN   | enable dropped; keep rotating until the next wrap into phase 0
// ----------------------------------------------------------------------------
module phase_generator #(
    parameter int NUM_PHASES = 4,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                          clkIn,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          step,
    input  logic [DIV_WIDTH-1:0]          holdCycles,
    output logic [NUM_PHASES-1:0]         clkOut,
    output logic [$clog2(NUM_PHASES)-1:0] phaseIdx,
    output logic                          cycleDone,
    output logic                          running
);

    localparam int IDX_W = $clog2(NUM_PHASES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [DIV_WIDTH-1:0] hold_cnt;
    logic [DIV_WIDTH-1:0] hold_cnt_next;
    logic                 advance;
    logic                 at_last;

    // The token sits on the last phase, so the next advance wraps to phase 0.
    assign at_last = (phaseIdx == IDX_W'(NUM_PHASES - 1));

    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        advance       = 1'b0;

        case (state)
            ST_IDLE: begin
                // enable wins over step: entering RUN never advances.
                if (enable) begin
                    state_next    = ST_RUN;
                    hold_cnt_next = holdCycles;
                end else if (step) begin
                    advance = 1'b1;
                end
            end

            ST_RUN, ST_DRAIN: begin
                if (hold_cnt == '0) begin
                    advance       = 1'b1;
                    hold_cnt_next = holdCycles;
                end else begin
                    hold_cnt_next = hold_cnt - DIV_WIDTH'(1);
                end

                if (state == ST_RUN) begin
                    if (!enable) begin
                        state_next = ST_DRAIN;
                    end
                end else begin
                    // Re-enable resumes without disturbing phase timing.
                    // Otherwise stop only once the token wraps into phase 0.
                    if (enable) begin
                        state_next = ST_RUN;
                    end else if (advance && at_last) begin
                        state_next = ST_IDLE;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (reset) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            clkOut    <= NUM_PHASES'(1);
            phaseIdx  <= '0;
            cycleDone <= 1'b0;
            running   <= 1'b0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
            if (advance) begin
                clkOut   <= {clkOut[NUM_PHASES-2:0], clkOut[NUM_PHASES-1]};
                phaseIdx <= at_last ? '0 : phaseIdx + IDX_W'(1);
            end
            cycleDone <= advance && at_last;
            running   <= (state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_phase_generator.sv
// ----------------------------------------------------------------------------
// tb_phase_generator
//
// Directed scenarios with literal expectations, followed by a randomized run.
// A behavioural model tracks the phase number, the mode and the cycles left
// in the current phase. Every cycle after the first reset, the DUT outputs
// are compared against values derived from that model.
// ----------------------------------------------------------------------------
module tb_phase_generator;

    localparam int NP = 4;
    localparam int DW = 8;

    logic          clkIn      = 1'b0;
    logic          reset      = 1'b0;
    logic          enable     = 1'b0;
    logic          step       = 1'b0;
    logic [DW-1:0] holdCycles = '0;
    logic [NP-1:0] clkOut;
    logic [1:0]    phaseIdx;
    logic          cycleDone;
    logic          running;

    int vectors     = 0;
    int miscompares = 0;

    phase_generator #(.NUM_PHASES(NP), .DIV_WIDTH(DW)) dut (
        .clkIn      (clkIn),
        .reset      (reset),
        .enable     (enable),
        .step       (step),
        .holdCycles (holdCycles),
        .clkOut     (clkOut),
        .phaseIdx   (phaseIdx),
        .cycleDone  (cycleDone),
        .running    (running)
    );

    always #5 clkIn = ~clkIn;

    // ------------------------------------------------------------------
    // Reference model: phase number, mode (0 idle, 1 run, 2 drain) and
    // cycles remaining in the current phase before it advances.
    // ------------------------------------------------------------------
    int m_phase = 0;
    int m_mode  = 0;
    int m_left  = 0;
    bit m_done  = 1'b0;
    bit m_valid = 1'b0;

    always @(posedge clkIn) begin : model
        bit adv;
        adv = 1'b0;
        if (reset) begin
            m_phase = 0;
            m_mode  = 0;
            m_left  = 0;
            m_done  = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_mode == 0) begin
                if (enable) begin
                    m_mode = 1;
                    m_left = int'(holdCycles);
                end else if (step) begin
                    adv = 1'b1;
                end
            end else begin
                if (m_left == 0) begin
                    adv    = 1'b1;
                    m_left = int'(holdCycles);
                end else begin
                    m_left = m_left - 1;
                end
                if (m_mode == 1 && !enable)
                    m_mode = 2;
                else if (m_mode == 2 && enable)
                    m_mode = 1;
                else if (m_mode == 2 && adv && m_phase == NP - 1)
                    m_mode = 0;
            end
            m_done = adv && (m_phase == NP - 1);
            if (adv)
                m_phase = (m_phase + 1) % NP;
        end
    end

    always @(negedge clkIn) begin : compare
        logic [NP-1:0] exp_clk;
        logic [1:0]    exp_idx;
        logic          exp_run;
        if (m_valid) begin
            exp_clk = NP'(1) << m_phase;
            exp_idx = 2'(m_phase);
            exp_run = (m_mode != 0);
            vectors++;
            if (clkOut !== exp_clk || phaseIdx !== exp_idx ||
                cycleDone !== m_done || running !== exp_run) begin
                miscompares++;
                $display("FAIL model_cmp t=%0t got clkOut=%b idx=%0d done=%b run=%b, want clkOut=%b idx=%0d done=%b run=%b",
                         $time, clkOut, phaseIdx, cycleDone, running,
                         exp_clk, exp_idx, m_done, exp_run);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed scenarios with hand-computed expectations
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clkIn);
        @(negedge clkIn);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    initial begin
        int  done_cnt;
        int  run_cnt;
        bit  found;

        @(negedge clkIn);

        // reset state
        reset = 1'b1;
        tick();
        chk("rst_clk",  32'(clkOut),    32'h1);
        chk("rst_idx",  32'(phaseIdx),  32'h0);
        chk("rst_done", 32'(cycleDone), 32'h0);
        chk("rst_run",  32'(running),   32'h0);

        // enable, holdCycles=0: rotate every cycle
        reset = 1'b0; enable = 1'b1; holdCycles = 8'd0;
        tick(); chk("h0_entry_clk", 32'(clkOut), 32'h1); chk("h0_entry_run", 32'(running), 32'h1);
                chk("h0_entry_done", 32'(cycleDone), 32'h0);
        tick(); chk("h0_p1_clk", 32'(clkOut), 32'h2); chk("h0_p1_idx", 32'(phaseIdx), 32'h1);
        tick(); chk("h0_p2_clk", 32'(clkOut), 32'h4); chk("h0_p2_idx", 32'(phaseIdx), 32'h2);
        tick(); chk("h0_p3_clk", 32'(clkOut), 32'h8); chk("h0_p3_done", 32'(cycleDone), 32'h0);
        tick(); chk("h0_wrap_clk", 32'(clkOut), 32'h1); chk("h0_wrap_done", 32'(cycleDone), 32'h1);
                chk("h0_wrap_idx", 32'(phaseIdx), 32'h0);
        tick(); chk("h0_p1b_clk", 32'(clkOut), 32'h2); chk("h0_p1b_done", 32'(cycleDone), 32'h0);

        // drop enable in phase 1: drain through 2, 3, stop on 0
        enable = 1'b0;
        tick(); chk("drain_p2_clk", 32'(clkOut), 32'h4); chk("drain_p2_run", 32'(running), 32'h1);
        tick(); chk("drain_p3_clk", 32'(clkOut), 32'h8);
        tick(); chk("drain_end_clk", 32'(clkOut), 32'h1); chk("drain_end_done", 32'(cycleDone), 32'h1);
                chk("drain_end_run", 32'(running), 32'h0);
        tick(); chk("idle_hold_clk", 32'(clkOut), 32'h1); chk("idle_hold_done", 32'(cycleDone), 32'h0);

        // stepping in IDLE
        step = 1'b1;
        tick(); chk("step1_clk", 32'(clkOut), 32'h2);
        tick(); chk("step2_clk", 32'(clkOut), 32'h4);
        tick(); chk("step3_clk", 32'(clkOut), 32'h8);
        tick(); chk("step4_clk", 32'(clkOut), 32'h1); chk("step4_done", 32'(cycleDone), 32'h1);
                chk("step4_run", 32'(running), 32'h0);
        step = 1'b0;
        tick(); chk("step_off_clk", 32'(clkOut), 32'h1);
        step = 1'b1; enable = 1'b1;
        tick(); chk("step_en_clk", 32'(clkOut), 32'h1); chk("step_en_run", 32'(running), 32'h1);
        step = 1'b0;

        // holdCycles=5, reset mid-phase 2
        reset = 1'b1;
        tick();
        reset = 1'b0; enable = 1'b1; holdCycles = 8'd5;
        tick();
        repeat (6) tick();
        chk("h5_p1_clk", 32'(clkOut), 32'h2);
        repeat (6) tick();
        chk("h5_p2_clk", 32'(clkOut), 32'h4);
        repeat (2) tick();
        chk("h5_mid_clk", 32'(clkOut), 32'h4);
        reset = 1'b1;
        tick();
        chk("h5_rst_clk", 32'(clkOut), 32'h1); chk("h5_rst_idx", 32'(phaseIdx), 32'h0);
        chk("h5_rst_run", 32'(running), 32'h0); chk("h5_rst_done", 32'(cycleDone), 32'h0);
        reset = 1'b0; enable = 1'b0;
        repeat (5) tick();
        chk("h5_idle_clk", 32'(clkOut), 32'h1); chk("h5_idle_run", 32'(running), 32'h0);

        // holdCycles change mid-phase 1
        enable = 1'b1; holdCycles = 8'd2;
        tick();
        tick(); tick();
        tick(); chk("hc_p1_first", 32'(clkOut), 32'h2);
        tick(); chk("hc_p1_second", 32'(clkOut), 32'h2);
        holdCycles = 8'd0;
        tick(); chk("hc_p1_third", 32'(clkOut), 32'h2);
        tick(); chk("hc_p2", 32'(clkOut), 32'h4);
        tick(); chk("hc_p3", 32'(clkOut), 32'h8);
        tick(); chk("hc_wrap", 32'(clkOut), 32'h1); chk("hc_wrap_done", 32'(cycleDone), 32'h1);

        // holdCycles=2 steady run: 12-cycle period
        holdCycles = 8'd2;
        tick();
        done_cnt = 0; run_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (cycleDone === 1'b1) done_cnt++;
            if (running === 1'b1) run_cnt++;
        end
        chk("h2_done_count", 32'(done_cnt), 32'd2);
        chk("h2_run_count", 32'(run_cnt), 32'd24);

        // reset coinciding with a wrap
        holdCycles = 8'd0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (clkOut === 4'h8) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("wrap_rst_reach_p3", 32'(found), 32'h1);
        reset = 1'b1;
        tick();
        chk("wrap_rst_done", 32'(cycleDone), 32'h0); chk("wrap_rst_clk", 32'(clkOut), 32'h1);
        reset = 1'b0; enable = 1'b0;

        // randomized run, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            step = ($urandom_range(0, 3) == 0);
            holdCycles = 8'($urandom_range(0, 3));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/phase_generator.md
PHASE_GENERATOR -- requirements
Module: phase_generator

Interface
REQ-001 The module SHALL have parameter NUM_PHASES, default 4, giving the number of phase outputs; legal values are 2 to 32.
REQ-002 The module SHALL have parameter DIV_WIDTH, default 8, giving the width of the per-phase hold count; legal values are 1 to 16.
REQ-003 The module SHALL have clkIn, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have enable, input, 1 bit: run request, level-sensitive.
REQ-006 The module SHALL have step, input, 1 bit: single-phase advance request, sampled only in IDLE.
REQ-007 The module SHALL have holdCycles, input, DIV_WIDTH bits: each phase lasts holdCycles+1 clkIn cycles.
REQ-008 The module SHALL have clkOut, output, NUM_PHASES bits, registered: one-hot active phase.
REQ-009 The module SHALL have phaseIdx, output, clog2(NUM_PHASES) bits, registered: binary index of the set clkOut bit.
REQ-010 The module SHALL have cycleDone, output, 1 bit, registered: one-cycle pulse on wrap to phase 0.
REQ-011 The module SHALL have running, output, 1 bit, registered: high in RUN or DRAIN.

Function
REQ-012 The block SHALL implement states IDLE, RUN and DRAIN, plus a DIV_WIDTH-bit down-counter holdCnt.
REQ-013 clkOut SHALL be exactly one-hot at all times after reset, and phaseIdx SHALL equal the position of its set bit in every cycle.
REQ-014 A phase advance SHALL rotate clkOut left by one: bit i moves to bit i+1, and bit NUM_PHASES-1 moves to bit 0. phaseIdx SHALL increment modulo NUM_PHASES.
REQ-015 IDLE with enable=1: the next edge SHALL enter RUN and load holdCnt with holdCycles; clkOut is unchanged and running goes to 1.
REQ-016 In RUN or DRAIN:
- holdCnt!=0: holdCnt SHALL decrement and the phase is held.
- holdCnt==0: the phase SHALL advance and holdCnt SHALL reload with the current holdCycles.
REQ-017 holdCycles SHALL be sampled only on IDLE->RUN entry and at each phase advance. Changes mid-phase SHALL not alter the current phase's length.
REQ-018 With holdCycles=0, clkOut SHALL rotate every clkIn cycle, giving NUM_PHASES outputs of frequency F/NUM_PHASES, each shifted by one input period.
REQ-019 cycleDone SHALL be 1 for exactly the first cycle in which clkOut[0] is high after an advance from phase NUM_PHASES-1, in any state; it is 0 otherwise.
REQ-020 RUN with enable=0: the next edge SHALL enter DRAIN and keep counting/advancing.
REQ-021 DRAIN with enable=1: the next edge SHALL return to RUN, with no change to holdCnt or phase timing.
REQ-022 DRAIN SHALL end at the next advance into phase 0. On that edge the state SHALL become IDLE and running SHALL become 0; clkOut=1, phaseIdx=0, and cycleDone pulses.
REQ-023 DRAIN entered while in phase 0 SHALL run a full cycle before stopping.
REQ-024 IDLE with enable=0 and step=1: the next edge SHALL advance the phase by one, ignoring holdCycles. A step held high SHALL advance once per cycle.
REQ-025 In IDLE, enable SHALL take priority over step: if both are 1, the block enters RUN and does not advance.
REQ-026 step SHALL be ignored in RUN and DRAIN.
REQ-027 In IDLE without step, clkOut, phaseIdx and holdCnt SHALL hold. A later RUN SHALL resume from the current phase, not from phase 0.

Reset
REQ-028 reset=1 at a rising edge SHALL force the following, overriding all other inputs in any state including mid-phase and mid-DRAIN: state=IDLE, clkOut=1 (bit 0 only), phaseIdx=0, holdCnt=0, cycleDone=0, running=0.
REQ-029 Initial-block values SHALL match the reset values.
REQ-030 A reset coinciding with a wrap SHALL not produce a cycleDone pulse.

Verification (NUM_PHASES=4, DIV_WIDTH=8)
REQ-031 Reset, then enable=1, holdCycles=0:
- clkOut sequence 0001 (entry cycle), 0010, 0100, 1000, 0001.
- cycleDone=1 only with the second 0001.
- phaseIdx follows 0,1,2,3,0.
REQ-032 enable=1, holdCycles=2: each phase lasts 3 cycles; cycleDone pulses every 12 cycles; running=1 throughout.
REQ-033 holdCycles=2, then changed to 0 in the 2nd cycle of phase 1: phase 1 still lasts 3 cycles, then phases 2 and 3 last 1 cycle each.
REQ-034 holdCycles=0, enable dropped while in phase 1:
- Phases 2 and 3 complete.
- clkOut becomes 0001 with cycleDone=1 and running=0.
- clkOut stays at 0001 afterwards.
REQ-035 IDLE, step pulsed 4 times:
- clkOut goes 0010, 0100, 1000, then 0001 with cycleDone=1.
- Step with enable=1 simultaneously: enters RUN with no advance.
REQ-036 RUN with holdCycles=5, reset asserted in phase 2: on the next edge clkOut=0001, phaseIdx=0, running=0 and cycleDone=0; the block stays IDLE until enable=1.
